// File: rtl/gpio_port_irq.sv
// Memory-mapped GPIO port with direction control, atomic output set/clear/toggle,
// an input synchroniser and per-pin edge interrupts feeding one level irq.
module gpio_port_irq #(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   address,
    input  logic [W-1:0] databi,
    output logic [W-1:0] databo,
    input  logic         cen,
    input  logic         wr,
    input  logic [W-1:0] port_in,
    output logic [W-1:0] port_en,
    output logic [W-1:0] port_out,
    output logic         irq
);

    localparam int unsigned GW = $clog2(SYNC_STAGES + 2);

    localparam logic [3:0] ADDR_IN      = 4'd0;
    localparam logic [3:0] ADDR_DDR     = 4'd1;
    localparam logic [3:0] ADDR_OUT     = 4'd2;
    localparam logic [3:0] ADDR_OUT_SET = 4'd3;
    localparam logic [3:0] ADDR_OUT_CLR = 4'd4;
    localparam logic [3:0] ADDR_OUT_TGL = 4'd5;
    localparam logic [3:0] ADDR_IRQ_EN  = 4'd6;
    localparam logic [3:0] ADDR_STAT    = 4'd7;
    localparam logic [3:0] ADDR_RISE_EN = 4'd8;
    localparam logic [3:0] ADDR_FALL_EN = 4'd9;

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  prev_q;
    logic [GW-1:0] guard_q;
    logic [W-1:0]  irq_en_q;
    logic [W-1:0]  stat_q;
    logic [W-1:0]  rise_en_q;
    logic [W-1:0]  fall_en_q;

    logic          wr_c;
    logic          rd_c;
    logic [W-1:0]  sync_in_c;
    logic [W-1:0]  rise_c;
    logic [W-1:0]  fall_c;
    logic [W-1:0]  clr_c;
    logic [W-1:0]  rd_data_c;
    logic [W-1:0]  ddr_d;
    logic [W-1:0]  out_d;
    logic [W-1:0]  irq_en_d;
    logic [W-1:0]  stat_d;
    logic [W-1:0]  rise_en_d;
    logic [W-1:0]  fall_en_d;
    logic [GW-1:0] guard_d;
    logic          irq_d;

    assign sync_in_c = sync_q[SYNC_STAGES-1];

    // Bus decode, edge detection and next-state for every register
    always_comb begin
        wr_c      = cen & wr;
        rd_c      = cen & ~wr;
        ddr_d     = port_en;
        out_d     = port_out;
        irq_en_d  = irq_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_c     = '0;
        rise_c    = '0;
        fall_c    = '0;
        rd_data_c = '0;

        if (wr_c) begin
            case (address)
                ADDR_DDR:     ddr_d     = databi;
                ADDR_OUT:     out_d     = databi;
                ADDR_OUT_SET: out_d     = port_out | databi;
                ADDR_OUT_CLR: out_d     = port_out & ~databi;
                ADDR_OUT_TGL: out_d     = port_out ^ databi;
                ADDR_IRQ_EN:  irq_en_d  = databi;
                ADDR_STAT:    clr_c     = databi;
                ADDR_RISE_EN: rise_en_d = databi;
                ADDR_FALL_EN: fall_en_d = databi;
                default:      ;
            endcase
        end

        // Masked until the synchroniser holds real pin values after reset
        if (guard_q == '0) begin
            rise_c = sync_in_c & ~prev_q & rise_en_q;
            fall_c = ~sync_in_c & prev_q & fall_en_q;
        end

        // Set wins over a simultaneous W1C on the same bit
        stat_d = (stat_q & ~clr_c) | rise_c | fall_c;
        irq_d  = |(stat_d & irq_en_d);

        guard_d = (guard_q != '0) ? guard_q - GW'(1) : guard_q;

        case (address)
            ADDR_IN:      rd_data_c = sync_in_c;
            ADDR_DDR:     rd_data_c = port_en;
            ADDR_OUT:     rd_data_c = port_out;
            ADDR_IRQ_EN:  rd_data_c = irq_en_q;
            ADDR_STAT:    rd_data_c = stat_q;
            ADDR_RISE_EN: rd_data_c = rise_en_q;
            ADDR_FALL_EN: rd_data_c = fall_en_q;
            default:      rd_data_c = '0;
        endcase
    end

    // Input synchroniser and previous-sample register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= port_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_in_c;
        end
    end

    // Control/status registers, read data and irq
    always_ff @(posedge clk) begin
        if (rst) begin
            port_en   <= '0;
            port_out  <= '0;
            irq_en_q  <= '0;
            stat_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            guard_q   <= GW'(SYNC_STAGES + 1);
            databo    <= '0;
            irq       <= 1'b0;
        end else begin
            port_en   <= ddr_d;
            port_out  <= out_d;
            irq_en_q  <= irq_en_d;
            stat_q    <= stat_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            guard_q   <= guard_d;
            irq       <= irq_d;
            if (rd_c) begin
                databo <= rd_data_c;
            end
        end
    end

endmodule
